// File: rtl/rgb_2g_pkg.sv
// Shared defaults and helpers for the RGB-to-grayscale converter.
// Luma weights are 8-bit fixed point and must sum to 2^FRAC_BITS.
package rgb_2g_pkg;

  localparam int unsigned NUM_PIXELS_DEF = 2361344;  // 2048 x 1153
  localparam int unsigned W_R_DEF        = 77;
  localparam int unsigned W_G_DEF        = 150;
  localparam int unsigned W_B_DEF        = 29;
  localparam int unsigned FRAC_BITS_DEF  = 8;
  localparam int unsigned ACC_W          = 18;

  // Round-half-up, shift out the fraction, then clamp to 8 bits.
  function automatic logic [7:0] round_sat8(input logic [ACC_W-1:0] acc,
                                            input int unsigned     frac_bits);
    logic [ACC_W-1:0] rnd;
    logic [ACC_W-1:0] shifted;
    rnd     = acc + (ACC_W'(1) << (frac_bits - 1));
    shifted = rnd >> frac_bits;
    if (shifted > ACC_W'(255))
      return 8'hff;
    else
      return shifted[7:0];
  endfunction

endpackage

// File: rtl/rgb_2g_luma_mac.sv
// Combinational weighted sum of R, G, B with rounding and 8-bit saturation.
module luma_mac
  import rgb_2g_pkg::*;
#(
  parameter int unsigned W_R       = W_R_DEF,
  parameter int unsigned W_G       = W_G_DEF,
  parameter int unsigned W_B       = W_B_DEF,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  output logic [7:0] luma
);

  logic [ACC_W-1:0] prod_r;
  logic [ACC_W-1:0] prod_g;
  logic [ACC_W-1:0] prod_b;
  logic [ACC_W-1:0] acc;

  always_comb begin
    prod_r = ACC_W'(W_R) * ACC_W'(data_0);
    prod_g = ACC_W'(W_G) * ACC_W'(data_1);
    prod_b = ACC_W'(W_B) * ACC_W'(data_2);
    acc    = prod_r + prod_g + prod_b;
    luma   = round_sat8(acc, FRAC_BITS);
  end

endmodule

// File: rtl/rgb_2g.sv
// RGB-to-grayscale top: registered luma result and sticky end-of-frame flag.
// One pixel is accepted on every clock edge; there is no handshake.
module rgb_2g
  import rgb_2g_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int unsigned W_R        = W_R_DEF,
  parameter int unsigned W_G        = W_G_DEF,
  parameter int unsigned W_B        = W_B_DEF,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data_0,
  input  logic [7:0]         data_1,
  input  logic [7:0]         data_2,
  input  logic signed [31:0] pixel,
  output logic [7:0]         result,
  output logic               done
);

  localparam logic signed [31:0] LAST_PIX = 32'(NUM_PIXELS - 1);

  if (W_R + W_G + W_B != 2 ** FRAC_BITS) begin : g_bad_weights
    $error("rgb_2g: luma weights must sum to 2^FRAC_BITS");
  end

  logic [7:0] luma;
  logic       is_last;

  luma_mac #(
    .W_R       (W_R),
    .W_G       (W_G),
    .W_B       (W_B),
    .FRAC_BITS (FRAC_BITS)
  ) u_luma_mac (
    .data_0 (data_0),
    .data_1 (data_1),
    .data_2 (data_2),
    .luma   (luma)
  );

  // Exact match only: negative or out-of-range indices never end the frame.
  assign is_last = (pixel == LAST_PIX);

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= 8'h00;
      done   <= 1'b0;
    end else begin
      result <= luma;
      if (is_last)
        done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb_2g.sv
// Scoreboard bench for rgb_2g with a 4-pixel frame; directed vectors with
// hand-computed luma values.
module tb_rgb_2g;

  typedef struct {
    logic [7:0] res;
    logic       dn;
    string      name;
  } exp_t;

  logic               clk;
  logic               rst;
  logic [7:0]         data_0;
  logic [7:0]         data_1;
  logic [7:0]         data_2;
  logic signed [31:0] pixel;
  logic [7:0]         result;
  logic               done;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  rgb_2g #(.NUM_PIXELS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_0 (data_0),
    .data_1 (data_1),
    .data_2 (data_2),
    .pixel  (pixel),
    .result (result),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic apply(input string name, input logic r_st,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input int pix, input logic [7:0] e_res, input logic e_dn);
    exp_t e;
    @(negedge clk);
    rst    = r_st;
    data_0 = r;
    data_1 = g;
    data_2 = b;
    pixel  = pix;
    e.res  = e_res;
    e.dn   = e_dn;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge produces an output; check those a vector was issued for.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (result !== e.res || done !== e.dn) begin
          n_err++;
          $display("FAIL %s: got result=%0d done=%b, want result=%0d done=%b",
                   e.name, result, done, e.res, e.dn);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    data_0 = 8'd0;
    data_1 = 8'd0;
    data_2 = 8'd0;
    pixel  = 0;

    apply("reset",        1'b1,   0,   0,   0,   0,   0, 1'b0);
    apply("black",        1'b0,   0,   0,   0,  -1,   0, 1'b0);
    apply("white",        1'b0, 255, 255, 255,   7, 255, 1'b0);
    apply("red",          1'b0, 255,   0,   0, 100,  77, 1'b0);
    apply("green",        1'b0,   0, 255,   0,   4, 149, 1'b0);
    apply("blue",         1'b0,   0,   0, 255,  -5,  29, 1'b0);
    apply("mixed",        1'b0, 100, 150, 200,   2, 141, 1'b0);
    // Back-to-back frame, pixel 0..3
    apply("frame_p0",     1'b0,  10,  20,  30,   0,  18, 1'b0);
    apply("frame_p1",     1'b0, 200, 100,  50,   1, 124, 1'b0);
    apply("frame_p2",     1'b0,  50,  60,  70,   2,  58, 1'b0);
    apply("frame_p3",     1'b0,   1,   2,   3,   3,   2, 1'b1);
    apply("sticky_p4",    1'b0,   0,   0,   0,   4,   0, 1'b1);
    apply("sticky_p5",    1'b0, 255, 255, 255,   5, 255, 1'b1);
    apply("sticky_neg",   1'b0, 100, 150, 200,  -1, 141, 1'b1);
    apply("sticky_p2",    1'b0, 255,   0,   0,   2,  77, 1'b1);
    apply("rst_mid",      1'b1, 255, 255, 255,   1,   0, 1'b0);
    apply("after_rst",    1'b0,  10,  20,  30,   0,  18, 1'b0);
    apply("last_again",   1'b0,   0, 255,   0,   3, 149, 1'b1);
    apply("rst_on_last",  1'b1, 255, 255, 255,   3,   0, 1'b0);
    apply("restart_p0",   1'b0,   0,   0, 255,   0,  29, 1'b0);
    apply("restart_p2",   1'b0, 200, 100,  50,   2, 124, 1'b0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected outputs never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_2g.md
RGB_2G -- requirements
Module: rgb_2g

Interface
REQ-001 Parameter NUM_PIXELS, default 2361344 (2048x1153), meaning pixels per frame.
REQ-002 Parameters W_R, W_G, W_B, defaults 77, 150, 29, meaning luma weights in 8-bit fixed point (sum SHALL be 256).
REQ-003 Parameter FRAC_BITS, default 8, meaning the weight fraction width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 data_0  input  8  red component, unsigned.
REQ-007 data_1  input  8  green component, unsigned.
REQ-008 data_2  input  8  blue component, unsigned.
REQ-009 pixel  input  32  signed index of the pixel currently on data_0..2.
REQ-010 result  output  8  grayscale value, registered.
REQ-011 done  output  1  frame-complete flag, registered, sticky.

Function
REQ-012 On every rising edge with rst low, the block SHALL sample data_0..2 and pixel; there is no input handshake, and every edge carries one pixel.
REQ-013 result SHALL update on the same edge to round((W_R*R + W_G*G + W_B*B) / 2^FRAC_BITS), giving a latency of 1 cycle from sampling.
REQ-014 Arithmetic SHALL use an unsigned accumulator of at least 18 bits; rounding adds 2^(FRAC_BITS-1) before the right shift by FRAC_BITS.
REQ-015 A shifted value above 255 SHALL saturate to 255; no wrap-around is permitted.
REQ-016 done SHALL go high on the edge where the sampled pixel equals NUM_PIXELS-1.
REQ-017 Once high, done SHALL stay high until rst, regardless of later pixel values.
REQ-018 Negative pixel values, or values of NUM_PIXELS or more, SHALL not set done; result still computes normally for them.
REQ-019 After done is high, result SHALL keep tracking the inputs per REQ-013.
REQ-020 If rst and the final-pixel condition occur on the same edge, rst SHALL win: done = 0, result = 0.

Reset
REQ-021 On a rising edge with rst high, result SHALL be set to 8'h00 and done to 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame; the next frame restarts with no residual state.
REQ-023 The block SHALL contain no asynchronous logic and no initial-value dependence.

Structure
REQ-024 A shared package rgb_2g_pkg SHALL hold the default NUM_PIXELS, W_R/W_G/W_B, FRAC_BITS and the accumulator width constant.
REQ-025 One sub-module, luma_mac, SHALL be used: combinational weighted sum, rounding and saturation, 8-bit out.
REQ-026 The top level SHALL hold only the result/done registers and the last-pixel compare.
REQ-027 An elaboration-time check SHALL flag W_R+W_G+W_B != 2^FRAC_BITS.

Verification
REQ-028 Gray-level extremes: (R,G,B) = (0,0,0) -> result 0; (255,255,255) -> result 255, with no overflow.
REQ-029 Single channels: (255,0,0) -> 77; (0,255,0) -> 149; (0,0,255) -> 29; each on the edge after the one where it is applied.
REQ-030 Mixed pixel: (100,150,200) -> 141; a back-to-back stream of 4 distinct pixels -> 4 results with 1-cycle latency and no bubbles.
REQ-031 Frame end with NUM_PIXELS overridden to 4: pixel = 0..3 -> done rises on the edge sampling pixel 3 and stays 1 for pixel 4, 5 and -1.
REQ-032 Reset: rst high mid-stream with done = 1 -> result 0 and done 0 on the next edge; rst on the same edge as pixel = NUM_PIXELS-1 -> done 0.
